cfg_chain_loader: RTL and testbench

- Configuration writer for the fabric's serial config chain.
- Accepts configuration words over a valid/ready stream and shifts them bit-serially, LSB first, into the chain of config cells. Those cells hold the select and enable bits of the fabric's configurable muxes.
- After the last bit it pulses a latch strobe so downstream cells commit the new values atomically, then signals completion.
- Sits between the bitstream source (host interface or test harness) and the tile config chain.

---
 rtl/cfg_chain_loader.sv | 149 ++++++++++++++
 tb/tb_cfg_chain_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// Serial config-chain writer: streams words LSB-first into the chain, then strobes latch and done.
// First shift two cycles after start; in_ready drops while a word is mid-shift (no bubble between words).
module cfg_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_bit,
    output logic              cfg_shift_en,
    output logic              cfg_latch,
    output logic              busy,
    output logic              done
);

    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BIT_W  = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W = $clog2(NWORDS + 1);
    localparam int LEFT_W = $clog2(WORD_W + 1);

    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CHAIN_LEN - 1);
    localparam logic [BIT_W-1:0]  FULL_BITS = BIT_W'(CHAIN_LEN);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [WCNT_W-1:0] ALL_WORDS = WCNT_W'(NWORDS);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [LEFT_W-1:0] WORD_BITS = LEFT_W'(WORD_W);
    localparam logic [LEFT_W-1:0] ONE_LEFT  = LEFT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_LATCH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [WCNT_W-1:0]   r_word_cnt;
    logic [WORD_W-1:0]   r_buf;
    logic [LEFT_W-1:0]   r_left;
    logic                r_cfg_bit;
    logic                r_shift_en;
    logic                r_cfg_latch;
    logic                r_busy;
    logic                r_done;

    logic                w_buf_last;
    logic                w_chain_last;
    logic                w_in_ready;
    logic                w_take;
    logic [WORD_W-1:0]   w_buf_sh;

    // The holding buffer is valid exactly when a bit is on the wire, so r_shift_en doubles as buffer-valid.
    assign w_buf_last   = r_shift_en && (r_left == ONE_LEFT);
    assign w_chain_last = r_shift_en && (r_bit_cnt == LAST_BIT);
    assign w_in_ready   = (r_state == S_LOAD) && (r_word_cnt < ALL_WORDS) &&
                          (!r_shift_en || (w_buf_last && !w_chain_last));
    assign w_take       = in_valid && w_in_ready;
    assign w_buf_sh     = r_buf >> 1;

    assign in_ready     = w_in_ready;
    assign cfg_bit      = r_cfg_bit;
    assign cfg_shift_en = r_shift_en;
    assign cfg_latch    = r_cfg_latch;
    assign busy         = r_busy;
    assign done         = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_buf       <= '0;
            r_left      <= '0;
            r_cfg_bit   <= 1'b0;
            r_shift_en  <= 1'b0;
            r_cfg_latch <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt  <= '0;
                    r_word_cnt <= '0;
                    r_buf      <= '0;
                    r_left     <= '0;
                    r_cfg_bit  <= 1'b0;
                    r_shift_en <= 1'b0;
                    r_done     <= 1'b0;
                    if (start) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_chain_last) begin
                        // Remaining high bits of the final word are dropped here.
                        r_bit_cnt   <= FULL_BITS;
                        r_buf       <= '0;
                        r_left      <= '0;
                        r_cfg_bit   <= 1'b0;
                        r_shift_en  <= 1'b0;
                        r_cfg_latch <= 1'b1;
                        r_state     <= S_LATCH;
                    end else if (w_take) begin
                        r_buf      <= in_data;
                        r_left     <= WORD_BITS;
                        r_cfg_bit  <= in_data[0];
                        r_shift_en <= 1'b1;
                        r_word_cnt <= r_word_cnt + WCNT_ONE;
                        if (r_shift_en) begin
                            r_bit_cnt <= r_bit_cnt + BIT_ONE;
                        end
                    end else if (r_shift_en) begin
                        r_bit_cnt <= r_bit_cnt + BIT_ONE;
                        if (w_buf_last) begin
                            r_buf      <= '0;
                            r_left     <= '0;
                            r_cfg_bit  <= 1'b0;
                            r_shift_en <= 1'b0;
                        end else begin
                            r_buf     <= w_buf_sh;
                            r_left    <= r_left - ONE_LEFT;
                            r_cfg_bit <= w_buf_sh[0];
                        end
                    end
                end
                S_LATCH: begin
                    r_cfg_latch <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: three instances cover the default, exact-fit and single-bit chains.
module tb_cfg_chain_loader;

    logic       clk;
    logic       rst_n;
    logic [2:0] start;
    logic [2:0] vld;
    logic [7:0] din [3];
    wire  [2:0] rdy;
    wire  [2:0] cbit;
    wire  [2:0] shen;
    wire  [2:0] latch;
    wire  [2:0] busy;
    wire  [2:0] dn;

    int n_pass  = 0;
    int n_total = 0;
    int nsh_r;
    int lat_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(12)) u_dflt (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .in_data(din[0]), .in_valid(vld[0]),
        .in_ready(rdy[0]), .cfg_bit(cbit[0]), .cfg_shift_en(shen[0]), .cfg_latch(latch[0]),
        .busy(busy[0]), .done(dn[0])
    );

    cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(16)) u_fit (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .in_data(din[1]), .in_valid(vld[1]),
        .in_ready(rdy[1]), .cfg_bit(cbit[1]), .cfg_shift_en(shen[1]), .cfg_latch(latch[1]),
        .busy(busy[1]), .done(dn[1])
    );

    cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(1)) u_one (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .in_data(din[2]), .in_valid(vld[2]),
        .in_ready(rdy[2]), .cfg_bit(cbit[2]), .cfg_shift_en(shen[2]), .cfg_latch(latch[2]),
        .busy(busy[2]), .done(dn[2])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_idle(input int sel, input string tag);
        chk({tag, "/in_ready"},     32'(rdy[sel]),   32'd0);
        chk({tag, "/cfg_bit"},      32'(cbit[sel]),  32'd0);
        chk({tag, "/cfg_shift_en"}, 32'(shen[sel]),  32'd0);
        chk({tag, "/cfg_latch"},    32'(latch[sel]), 32'd0);
        chk({tag, "/busy"},         32'(busy[sel]),  32'd0);
        chk({tag, "/done"},         32'(dn[sel]),    32'd0);
    endtask

    task automatic run_load(input int sel, input int nsup, input logic [7:0] w0,
                            input logic [7:0] w1, input logic [7:0] w2, input int gap,
                            input int exp_len, input int exp_words, input logic [15:0] exp_bits,
                            input logic poke, input string tag);
        logic [7:0]  words [3];
        logic [15:0] bits;
        logic        take;
        int idx, gap_left, nsh, first, last, lat_n, lat_c, done_c;
        int busy_lat, busy_done, stray, gaps, late_rdy, extra_rdy, takes;
        words[0] = w0; words[1] = w1; words[2] = w2;
        bits = '0; idx = 0; gap_left = gap; nsh = 0; first = -1; last = -1;
        lat_n = 0; lat_c = -1; done_c = -1; busy_lat = 0; busy_done = 1;
        stray = 0; gaps = 0; late_rdy = 0; extra_rdy = 0; takes = 0;

        start[sel] = 1'b1;
        step();
        start[sel] = 1'b0;
        chk({tag, "/busy_after_start"},  32'(busy[sel]), 32'd1);
        chk({tag, "/ready_after_start"}, 32'(rdy[sel]),  32'd1);
        chk({tag, "/no_shift_yet"},      32'(shen[sel]), 32'd0);

        for (int cyc = 0; cyc < 80; cyc++) begin
            if (shen[sel]) begin
                if (first < 0) first = cyc;
                if (nsh < 16) bits[nsh] = cbit[sel];
                nsh++;
                last = cyc;
            end else begin
                if (cbit[sel]) stray++;
                if (first >= 0 && lat_c < 0 && !latch[sel]) gaps++;
            end
            if (latch[sel]) begin
                lat_n++;
                lat_c = cyc;
                busy_lat = int'(busy[sel]);
            end
            if (dn[sel]) begin
                done_c = cyc;
                busy_done = int'(busy[sel]);
            end
            if (lat_c >= 0 && rdy[sel]) late_rdy++;
            if (idx >= exp_words && rdy[sel]) extra_rdy++;
            if (done_c >= 0 && cyc >= done_c + 2) break;

            if (idx == 1 && rdy[sel] && gap_left > 0) begin
                vld[sel] = 1'b0;
                gap_left--;
            end else begin
                vld[sel] = (idx < nsup);
            end
            din[sel]   = (idx < 3) ? words[idx] : 8'h00;
            start[sel] = poke && cyc >= 2 && cyc <= 4;
            take       = vld[sel] && rdy[sel];
            step();
            if (take) begin
                idx++;
                takes++;
            end
        end
        vld[sel]   = 1'b0;
        start[sel] = 1'b0;

        chk({tag, "/shift_count"},   nsh,       exp_len);
        chk({tag, "/chain_bits"},    32'(bits), 32'(exp_bits));
        chk({tag, "/first_shift"},   first,     1);
        chk({tag, "/last_shift"},    last,      exp_len + gap);
        chk({tag, "/stall_cycles"},  gaps,      gap);
        chk({tag, "/latch_pulses"},  lat_n,     1);
        chk({tag, "/latch_cycle"},   lat_c,     exp_len + gap + 1);
        chk({tag, "/busy_at_latch"}, busy_lat,  1);
        chk({tag, "/done_cycle"},    done_c,    exp_len + gap + 2);
        chk({tag, "/busy_at_done"},  busy_done, 0);
        chk({tag, "/words_taken"},   takes,     exp_words);
        chk({tag, "/bit_when_idle"}, stray,     0);
        chk({tag, "/ready_late"},    late_rdy,  0);
        chk({tag, "/ready_extra"},   extra_rdy, 0);
        chk({tag, "/end_busy"},      32'(busy[sel]), 32'd0);
        chk({tag, "/end_ready"},     32'(rdy[sel]),  32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = '0;
        vld   = '0;
        for (int i = 0; i < 3; i++) din[i] = 8'h00;

        repeat (2) step();
        chk_idle(0, "reset");
        chk_idle(2, "reset_one");
        rst_n = 1'b1;
        step();
        chk_idle(0, "idle");

        // A word offered while idle must not be consumed by the next load.
        vld[0] = 1'b1;
        din[0] = 8'hFF;
        repeat (2) step();
        chk("idle_valid/in_ready", 32'(rdy[0]), 32'd0);
        vld[0] = 1'b0;

        run_load(0, 2, 8'hA5, 8'h3C, 8'h00, 0, 12, 2, 16'h0CA5, 1'b0, "basic");
        step();
        run_load(0, 2, 8'hA5, 8'h3C, 8'h00, 3, 12, 2, 16'h0CA5, 1'b0, "stall");
        step();
        run_load(0, 3, 8'hA5, 8'h3C, 8'hFF, 0, 12, 2, 16'h0CA5, 1'b1, "oversupply");
        step();

        // Reset in the middle of a load.
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        vld[0] = 1'b1;
        din[0] = 8'hA5;
        nsh_r = 0;
        for (int c = 0; c < 20 && nsh_r < 5; c++) begin
            step();
            if (shen[0]) nsh_r++;
        end
        chk("midrst/shifts_before", nsh_r, 5);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk_idle(0, "midrst");
        vld[0] = 1'b0;
        lat_seen = 0;
        repeat (3) begin
            step();
            if (latch[0]) lat_seen++;
        end
        #2 rst_n = 1'b1;
        repeat (4) begin
            step();
            if (latch[0]) lat_seen++;
        end
        chk("midrst/latch_never", lat_seen, 0);
        chk("midrst/busy_after", 32'(busy[0]), 32'd0);
        run_load(0, 2, 8'hA5, 8'h3C, 8'h00, 0, 12, 2, 16'h0CA5, 1'b0, "after_rst");
        step();

        run_load(1, 2, 8'h01, 8'h80, 8'h00, 0, 16, 2, 16'h8001, 1'b0, "exact_fit");
        step();
        run_load(2, 1, 8'hFE, 8'h00, 8'h00, 0, 1, 1, 16'h0000, 1'b0, "single_bit");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
